jt51_chmix: RTL and testbench

JT51_CHMIX -- requirements
Module: jt51_chmix

---
 rtl/jt51_chmix.sv | 139 +++++++++++++
 tb/tb_jt51_chmix.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_chmix.sv
// Channel mixer: accumulates carrier outputs per channel over a 32-slot frame and emits an L/R pair.
// Define JT51_CHMIX_SAT_EN to saturate the 19-bit sums to OUTW bits instead of wrapping.
module jt51_chmix #(
    parameter int unsigned OUTW = 16
) (
    input  logic                   rst,
    input  logic                   clk,
    input  logic                   cen,
    input  logic                   zero,
    input  logic signed [13:0]     op_in,
    input  logic [2:0]             con_I,
    input  logic [1:0]             rl_I,
    output logic signed [OUTW-1:0] left,
    output logic signed [OUTW-1:0] right,
    output logic                   sample
);

    logic [4:0]         r_cnt;
    logic signed [15:0] r_acc     [8];
    logic signed [15:0] r_hold    [8];
    logic [1:0]         r_rl      [8];
    logic [1:0]         r_hold_rl [8];
    logic signed [18:0] r_sum_l;
    logic signed [18:0] r_sum_r;
    logic               r_valid;

    logic [4:0]         w_slot;
    logic [1:0]         w_op;
    logic [2:0]         w_ch;
    logic               w_carrier;
    logic signed [15:0] w_op_ext;
    logic signed [15:0] w_acc_new;
    logic [1:0]         w_rl_new;
    logic signed [18:0] w_hold_ext;
    logic [1:0]         w_hold_rl;
    logic signed [18:0] w_sum_l_nx;
    logic signed [18:0] w_sum_r_nx;
    logic signed [OUTW-1:0] w_left_red;
    logic signed [OUTW-1:0] w_right_red;

    assign w_slot   = zero ? 5'd0 : r_cnt;
    assign w_op     = w_slot[4:3];
    assign w_ch     = w_slot[2:0];
    assign w_op_ext = {{2{op_in[13]}}, op_in};

    // Operator order per slot group is M1, M2, C1, C2
    always_comb begin
        w_carrier = 1'b0;
        case (con_I)
            3'd4:        w_carrier = w_op[0];
            3'd5, 3'd6:  w_carrier = (w_op != 2'd0);
            3'd7:        w_carrier = 1'b1;
            default:     w_carrier = (w_op == 2'd3);
        endcase
    end

    always_comb begin
        w_acc_new = r_acc[w_ch];
        if (w_op == 2'd0) begin
            w_acc_new = w_carrier ? w_op_ext : 16'sd0;
        end else if (w_carrier) begin
            w_acc_new = r_acc[w_ch] + w_op_ext;
        end
        w_rl_new = (w_op == 2'd3) ? rl_I : r_rl[w_ch];
    end

    always_comb begin
        w_hold_ext = {{3{r_hold[w_ch][15]}}, r_hold[w_ch]};
        w_hold_rl  = r_hold_rl[w_ch];
        w_sum_l_nx = ((w_slot == 5'd0) ? 19'sd0 : r_sum_l) + (w_hold_rl[0] ? w_hold_ext : 19'sd0);
        w_sum_r_nx = ((w_slot == 5'd0) ? 19'sd0 : r_sum_r) + (w_hold_rl[1] ? w_hold_ext : 19'sd0);
    end

`ifdef JT51_CHMIX_SAT_EN
    localparam logic signed [18:0] SatMax = 19'((1 << (OUTW - 1)) - 1);
    localparam logic signed [18:0] SatMin = 19'(-(1 << (OUTW - 1)));

    always_comb begin
        w_left_red = r_sum_l[OUTW-1:0];
        if (r_sum_l > SatMax) begin
            w_left_red = SatMax[OUTW-1:0];
        end else if (r_sum_l < SatMin) begin
            w_left_red = SatMin[OUTW-1:0];
        end
        w_right_red = r_sum_r[OUTW-1:0];
        if (r_sum_r > SatMax) begin
            w_right_red = SatMax[OUTW-1:0];
        end else if (r_sum_r < SatMin) begin
            w_right_red = SatMin[OUTW-1:0];
        end
    end
`else
    always_comb begin
        w_left_red  = r_sum_l[OUTW-1:0];
        w_right_red = r_sum_r[OUTW-1:0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 5'd0;
            r_sum_l <= 19'sd0;
            r_sum_r <= 19'sd0;
            r_valid <= 1'b0;
            left    <= '0;
            right   <= '0;
            sample  <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_acc[k]     <= 16'sd0;
                r_hold[k]    <= 16'sd0;
                r_rl[k]      <= 2'd0;
                r_hold_rl[k] <= 2'd0;
            end
        end else if (cen) begin
            r_cnt       <= zero ? 5'd1 : r_cnt + 5'd1;
            r_acc[w_ch] <= w_acc_new;
            r_rl[w_ch]  <= w_rl_new;
            // Slot 31 is C2 of channel 7, so its fresh value must go straight into the hold bank
            if (w_slot == 5'd31) begin
                for (int k = 0; k < 8; k++) begin
                    r_hold[k]    <= (3'(k) == w_ch) ? w_acc_new : r_acc[k];
                    r_hold_rl[k] <= (3'(k) == w_ch) ? w_rl_new : r_rl[k];
                end
                r_valid <= 1'b1;
            end
            if (w_slot[4:3] == 2'd0) begin
                r_sum_l <= w_sum_l_nx;
                r_sum_r <= w_sum_r_nx;
            end
            sample <= 1'b0;
            if ((w_slot == 5'd8) && r_valid) begin
                left   <= w_left_red;
                right  <= w_right_red;
                sample <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jt51_chmix.sv
// Scoreboard bench for jt51_chmix: expected L/R pairs are queued as slot 8 is driven
// and checked when the sample strobe rises.
module tb_jt51_chmix;

    localparam int unsigned OUTW = 16;

    logic                   rst;
    logic                   clk;
    logic                   cen;
    logic                   zero;
    logic signed [13:0]     op_in;
    logic [2:0]             con_I;
    logic [1:0]             rl_I;
    logic signed [OUTW-1:0] left;
    logic signed [OUTW-1:0] right;
    logic                   sample;

    jt51_chmix #(.OUTW(OUTW)) dut (
        .rst    (rst),
        .clk    (clk),
        .cen    (cen),
        .zero   (zero),
        .op_in  (op_in),
        .con_I  (con_I),
        .rl_I   (rl_I),
        .left   (left),
        .right  (right),
        .sample (sample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    typedef struct {
        int l;
        int r;
    } pair_t;

    pair_t      exp_q[$];
    pair_t      m_exp;
    bit         m_valid = 1'b0;
    int         cen_div = 1;
    logic [2:0] f_con [8];
    logic [1:0] f_rl  [8];
    int         f_op  [32];

    // Carrier mask per algorithm, bit n = operator n (M1, M2, C1, C2)
    bit [3:0] car_mask [8] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                               4'b1010, 4'b1110, 4'b1110, 4'b1111};

    function automatic int reduce(input int s);
`ifdef JT51_CHMIX_SAT_EN
        int hi;
        hi = (1 << (OUTW - 1)) - 1;
        if (s > hi) return hi;
        if (s < -hi - 1) return -hi - 1;
        return s;
`else
        logic [OUTW-1:0] t;
        t = s[OUTW-1:0];
        return int'($signed(t));
`endif
    endfunction

    task automatic frame_expect();
        int acc;
        int l;
        int r;
        l = 0;
        r = 0;
        for (int ch = 0; ch < 8; ch++) begin
            acc = 0;
            for (int op = 0; op < 4; op++) begin
                if (car_mask[f_con[ch]][op]) acc += f_op[op * 8 + ch];
            end
            if (f_rl[ch][0]) l += acc;
            if (f_rl[ch][1]) r += acc;
        end
        m_exp.l = reduce(l);
        m_exp.r = reduce(r);
    endtask

    // Non-enabled cycles carry random junk that the DUT must ignore
    task automatic drive_slot(input int s);
        if (s == 8 && m_valid) exp_q.push_back(m_exp);
        if (s == 31) begin
            frame_expect();
            m_valid = 1'b1;
        end
        for (int i = 0; i < cen_div; i++) begin
            @(negedge clk);
            if (i == cen_div - 1) begin
                zero  = (s == 0);
                op_in = 14'(f_op[s]);
                con_I = f_con[s % 8];
                rl_I  = f_rl[s % 8];
                cen   = 1'b1;
            end else begin
                zero  = 1'($urandom);
                op_in = 14'($urandom);
                con_I = 3'($urandom);
                rl_I  = 2'($urandom);
                cen   = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input int n);
        for (int s = 0; s < n; s++) drive_slot(s);
    endtask

    task automatic end_phase();
        @(negedge clk);
        cen = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_all100();
        for (int c = 0; c < 8; c++) begin
            f_con[c] = 3'd7;
            f_rl[c]  = 2'b11;
        end
        for (int s = 0; s < 32; s++) f_op[s] = 100;
    endtask

    task automatic set_wrap();
        for (int c = 0; c < 8; c++) begin
            f_con[c] = 3'd0;
            f_rl[c]  = 2'b01;
        end
        for (int s = 0; s < 32; s++) f_op[s] = (s >= 24) ? 8191 : 5000;
    endtask

    task automatic set_ch3();
        for (int c = 0; c < 8; c++) begin
            f_con[c] = 3'd4;
            f_rl[c]  = (c == 3) ? 2'b10 : 2'b00;
        end
        for (int s = 0; s < 32; s++) f_op[s] = (s[3] == 1'b1) ? -8192 : 1000;
    endtask

    task automatic set_random();
        for (int c = 0; c < 8; c++) begin
            f_con[c] = 3'($urandom_range(0, 7));
            f_rl[c]  = 2'($urandom_range(0, 3));
        end
        for (int s = 0; s < 32; s++) f_op[s] = int'($urandom_range(0, 16383)) - 8192;
    endtask

    logic prev_sample = 1'b0;
    int   hi_cnt      = 0;
    pair_t got_exp;

    always @(negedge clk) begin
        if (sample && !prev_sample) begin
            check_eq("pending_at_sample", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                got_exp = exp_q.pop_front();
                check_eq("left", int'(left), got_exp.l);
                check_eq("right", int'(right), got_exp.r);
            end
        end
        if (sample) begin
            hi_cnt++;
        end else if (prev_sample) begin
            check_eq("sample_width", hi_cnt, cen_div);
            hi_cnt = 0;
        end
        prev_sample = sample;
    end

    initial begin
        rst   = 1'b1;
        cen   = 1'b0;
        zero  = 1'b0;
        op_in = '0;
        con_I = '0;
        rl_I  = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_left", int'(left), 0);
        check_eq("reset_right", int'(right), 0);
        check_eq("reset_sample", int'(sample), 0);
        rst = 1'b0;

        // Full-rate cen
        cen_div = 1;
        set_all100();
        run_frame(32);
        set_wrap();
        run_frame(32);
        set_ch3();
        run_frame(32);
        for (int f = 0; f < 3; f++) begin
            set_random();
            run_frame(32);
        end
        set_all100();
        run_frame(10);
        end_phase();

        // cen one cycle in four
        cen_div = 4;
        set_all100();
        run_frame(32);
        set_wrap();
        run_frame(32);
        set_random();
        run_frame(32);
        set_ch3();
        run_frame(10);
        end_phase();

        // Reset mid-frame at slot 20
        cen_div = 1;
        set_random();
        run_frame(21);
        @(negedge clk);
        rst = 1'b1;
        cen = 1'b0;
        #1;
        check_eq("midrst_left", int'(left), 0);
        check_eq("midrst_right", int'(right), 0);
        check_eq("midrst_sample", int'(sample), 0);
        check_eq("queue_at_reset", exp_q.size(), 0);
        exp_q.delete();
        m_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        set_random();
        run_frame(32);
        set_wrap();
        run_frame(32);

        // Resync: zero reasserted at slot 12 of a frame
        set_ch3();
        run_frame(32);
        set_random();
        run_frame(12);
        set_random();
        run_frame(32);
        set_all100();
        run_frame(10);
        end_phase();

        check_eq("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
